// File: rtl/rr_mux_arbiter_pkg.sv
// Shared types and constants for the 4:1 round-robin mux arbiter.
// Imported by the picker, the interface and the top-level arbiter.
package rr_arb_pkg;

    localparam int NUM_REQ = 4;
    localparam int SEL_W   = 2;

    typedef enum logic {
        ARB_IDLE = 1'b0,
        ARB_BUSY = 1'b1
    } arb_state_t;

    // One-hot grant vector for a select index
    function automatic logic [NUM_REQ-1:0] sel_onehot(input logic [SEL_W-1:0] idx);
        logic [NUM_REQ-1:0] oh;
        oh      = '0;
        oh[idx] = 1'b1;
        return oh;
    endfunction

endpackage

// File: rtl/rr_mux_arbiter_if.sv
// Bundle of the four requester channels, the single output channel and the
// select/grant status of the round-robin mux arbiter.
// slave  : arbiter side (consumes requests, drives the output channel).
// master : environment side (drives requests and downstream ready).
interface rr_mux_arbiter_if #(
    parameter int WIDTH = 8
);
    import rr_arb_pkg::*;

    logic [NUM_REQ-1:0]       req_valid;
    logic [NUM_REQ*WIDTH-1:0] req_data;
    logic [NUM_REQ-1:0]       req_last;
    logic [NUM_REQ-1:0]       req_ready;
    logic                     out_valid;
    logic [WIDTH-1:0]         out_data;
    logic                     out_last;
    logic                     out_ready;
    logic [SEL_W-1:0]         ss;
    logic [NUM_REQ-1:0]       grant;

    modport slave (
        input  req_valid, req_data, req_last, out_ready,
        output req_ready, out_valid, out_data, out_last, ss, grant
    );

    modport master (
        output req_valid, req_data, req_last, out_ready,
        input  req_ready, out_valid, out_data, out_last, ss, grant
    );

endinterface

// File: rtl/rr_mux_arbiter_pick4.sv
// Combinational round-robin picker: returns the first requester with valid
// set, searching ptr, ptr+1, ptr+2, ptr+3 (mod 4).
module rr_pick4
    import rr_arb_pkg::*;
(
    input  logic [SEL_W-1:0]   ptr,
    input  logic [NUM_REQ-1:0] valid,
    output logic [SEL_W-1:0]   idx,
    output logic               found
);

    logic [SEL_W-1:0] cand;

    // Scan in priority order starting at ptr; the first hit wins
    always_comb begin
        idx   = '0;
        found = 1'b0;
        cand  = '0;
        for (int k = 0; k < NUM_REQ; k++) begin
            cand = ptr + SEL_W'(k);
            if (!found && valid[cand]) begin
                idx   = cand;
                found = 1'b1;
            end
        end
    end

endmodule

// File: rtl/rr_mux_arbiter.sv
// Round-robin arbiter and sequencer for the 4:1 selector datapath.
// Optional packet lock is enabled with `define ARB_PKT_LOCK_EN: the grant is
// held until a beat with last, or until MAX_BEATS transfers, whichever first.
// Without it every transfer releases the grant (per-beat interleave).
//
// state    | meaning
// ARB_IDLE | no grant, outputs quiet
// ARB_BUSY | one requester granted, its channel muxed to the output
module rr_mux_arbiter
    import rr_arb_pkg::*;
#(
    parameter int WIDTH     = 8,
    parameter int MAX_BEATS = 16
) (
    input  logic             clk,
    input  logic             rst_n,
    rr_mux_arbiter_if.slave  bus
);

    if (MAX_BEATS < 1) begin : g_bad_max_beats
        $error("rr_mux_arbiter: MAX_BEATS must be at least 1");
    end

    arb_state_t         state_q, state_d;
    logic [SEL_W-1:0]   ptr_q, ptr_d;
    logic [SEL_W-1:0]   ss_q, ss_d;
    logic [NUM_REQ-1:0] grant_q, grant_d;

    logic [SEL_W-1:0]   idle_idx, rel_idx, rel_ptr;
    logic               idle_found, rel_found;

    logic               active;
    logic               sel_valid, sel_last;
    logic [WIDTH-1:0]   sel_data;
    logic               xfer, release_ev;

    // Release re-arbitration gives the releasing requester lowest priority
    assign rel_ptr = ss_q + SEL_W'(1);

    rr_pick4 u_pick_idle (
        .ptr   (ptr_q),
        .valid (bus.req_valid),
        .idx   (idle_idx),
        .found (idle_found)
    );

    rr_pick4 u_pick_rel (
        .ptr   (rel_ptr),
        .valid (bus.req_valid),
        .idx   (rel_idx),
        .found (rel_found)
    );

    // Select the granted requester's channel; ss is always 0..3
    always_comb begin
        sel_data  = '0;
        sel_valid = 1'b0;
        sel_last  = 1'b0;
        for (int i = 0; i < NUM_REQ; i++) begin
            if (ss_q == SEL_W'(i)) begin
                sel_data  = bus.req_data[i*WIDTH +: WIDTH];
                sel_valid = bus.req_valid[i];
                sel_last  = bus.req_last[i];
            end
        end
    end

    // Output channel is only live while busy and out of reset, so nothing is
    // accepted in a reset cycle even though the grant flop clears at the edge
    assign active        = (state_q == ARB_BUSY) && rst_n;
    assign bus.out_valid = active && sel_valid;
    assign bus.out_data  = active ? sel_data : '0;
    assign bus.out_last  = active && sel_last;
    assign bus.req_ready = active ? (grant_q & {NUM_REQ{bus.out_ready}}) : '0;
    assign bus.ss        = ss_q;
    assign bus.grant     = grant_q;

    assign xfer = bus.out_valid && bus.out_ready;

`ifdef ARB_PKT_LOCK_EN
    localparam int CNT_W = $clog2(MAX_BEATS + 1);

    logic [CNT_W-1:0] beat_cnt_q, beat_cnt_d;
    logic             cnt_limit;

    assign cnt_limit  = (beat_cnt_q == CNT_W'(MAX_BEATS - 1));
    assign release_ev = xfer && (sel_last || cnt_limit);

    // Beat counter: cleared on every new grant, counts transfers otherwise
    always_comb begin
        beat_cnt_d = beat_cnt_q;
        if (state_q == ARB_IDLE || release_ev) begin
            beat_cnt_d = '0;
        end else if (xfer) begin
            beat_cnt_d = beat_cnt_q + CNT_W'(1);
        end
    end

    // Beat counter register
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            beat_cnt_q <= '0;
        end else begin
            beat_cnt_q <= beat_cnt_d;
        end
    end
`else
    assign release_ev = xfer;
`endif

    // Next-state: arbitrate from IDLE, re-arbitrate with no bubble on release
    always_comb begin
        state_d = state_q;
        ptr_d   = ptr_q;
        ss_d    = ss_q;
        grant_d = grant_q;
        unique case (state_q)
            ARB_IDLE: begin
                if (idle_found) begin
                    state_d = ARB_BUSY;
                    ss_d    = idle_idx;
                    grant_d = sel_onehot(idle_idx);
                end
            end
            ARB_BUSY: begin
                if (release_ev) begin
                    ptr_d = rel_ptr;
                    if (rel_found) begin
                        ss_d    = rel_idx;
                        grant_d = sel_onehot(rel_idx);
                    end else begin
                        state_d = ARB_IDLE;
                        grant_d = '0;
                    end
                end
            end
            default: begin
                state_d = ARB_IDLE;
                grant_d = '0;
            end
        endcase
    end

    // State, pointer, select and grant registers
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state_q <= ARB_IDLE;
            ptr_q   <= '0;
            ss_q    <= '0;
            grant_q <= '0;
        end else begin
            state_q <= state_d;
            ptr_q   <= ptr_d;
            ss_q    <= ss_d;
            grant_q <= grant_d;
        end
    end

endmodule

// File: tb/tb_rr_mux_arbiter.sv
// Directed, table-driven bench for rr_mux_arbiter (WIDTH=8, MAX_BEATS=4).
// Requester i drives constant data 8'h11*(i+1).
module tb_rr_mux_arbiter;

    typedef struct {
        logic       rst_n;
        logic [3:0] valid;
        logic [3:0] last;
        logic       ready;
        logic [1:0] ss;
        logic [3:0] grant;
        logic       ov;
        logic [3:0] rr;
        logic [7:0] data;
        logic       ol;
    } vec_t;

    logic clk = 1'b0;
    logic rst_n;
    int   checks = 0;
    int   errors = 0;
    vec_t vecs[23];

    rr_mux_arbiter_if #(.WIDTH(8)) bus_if ();

    rr_mux_arbiter #(.WIDTH(8), .MAX_BEATS(4)) dut (
        .clk   (clk),
        .rst_n (rst_n),
        .bus   (bus_if)
    );

    always #5 clk = ~clk;

    function automatic vec_t mk(logic r, logic [3:0] v, logic [3:0] l, logic rd,
                                logic [1:0] s, logic [3:0] g, logic o,
                                logic [3:0] q, logic [7:0] d, logic ol);
        vec_t t;
        t.rst_n = r; t.valid = v; t.last = l; t.ready = rd;
        t.ss = s; t.grant = g; t.ov = o; t.rr = q; t.data = d; t.ol = ol;
        return t;
    endfunction

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s actual=%0h expected=%0h", name, act, exp);
        end
    endtask

    // Drive one cycle of inputs, compare mid-cycle, then advance past the edge
    task automatic step(input string tag, input vec_t v);
        rst_n            = v.rst_n;
        bus_if.req_valid = v.valid;
        bus_if.req_last  = v.last;
        bus_if.out_ready = v.ready;
        @(negedge clk);
        chk({tag, ".ss"},        32'(bus_if.ss),        32'(v.ss));
        chk({tag, ".grant"},     32'(bus_if.grant),     32'(v.grant));
        chk({tag, ".out_valid"}, 32'(bus_if.out_valid), 32'(v.ov));
        chk({tag, ".req_ready"}, 32'(bus_if.req_ready), 32'(v.rr));
        chk({tag, ".out_data"},  32'(bus_if.out_data),  32'(v.data));
        chk({tag, ".out_last"},  32'(bus_if.out_last),  32'(v.ol));
        @(posedge clk);
        #1;
    endtask

    task automatic do_reset();
        rst_n            = 1'b0;
        bus_if.req_valid = 4'h0;
        bus_if.req_last  = 4'h0;
        bus_if.out_ready = 1'b0;
        repeat (2) @(posedge clk);
        #1;
    endtask

    initial begin
        bus_if.req_data = {8'h44, 8'h33, 8'h22, 8'h11};

        //            rst  valid  last   rdy ss  grant  ov rr     data   ol
        vecs[0]  = mk(0, 4'hF, 4'hF, 1, 0, 4'h0, 0, 4'h0, 8'h00, 0); // held in reset
        vecs[1]  = mk(0, 4'hF, 4'hF, 1, 0, 4'h0, 0, 4'h0, 8'h00, 0);
        vecs[2]  = mk(1, 4'hF, 4'hF, 1, 0, 4'h0, 0, 4'h0, 8'h00, 0); // IDLE, picks 0
        vecs[3]  = mk(1, 4'hF, 4'hF, 1, 0, 4'h1, 1, 4'h1, 8'h11, 1); // fairness 0..3,0,1
        vecs[4]  = mk(1, 4'hF, 4'hF, 1, 1, 4'h2, 1, 4'h2, 8'h22, 1);
        vecs[5]  = mk(1, 4'hF, 4'hF, 1, 2, 4'h4, 1, 4'h4, 8'h33, 1);
        vecs[6]  = mk(1, 4'hF, 4'hF, 1, 3, 4'h8, 1, 4'h8, 8'h44, 1);
        vecs[7]  = mk(1, 4'hF, 4'hF, 1, 0, 4'h1, 1, 4'h1, 8'h11, 1);
        vecs[8]  = mk(1, 4'hF, 4'hF, 1, 1, 4'h2, 1, 4'h2, 8'h22, 1);
        vecs[9]  = mk(1, 4'hF, 4'hF, 0, 2, 4'h4, 1, 4'h0, 8'h33, 1); // backpressure x5
        vecs[10] = mk(1, 4'hF, 4'hF, 0, 2, 4'h4, 1, 4'h0, 8'h33, 1);
        vecs[11] = mk(1, 4'hF, 4'hF, 0, 2, 4'h4, 1, 4'h0, 8'h33, 1);
        vecs[12] = mk(1, 4'hF, 4'hF, 0, 2, 4'h4, 1, 4'h0, 8'h33, 1);
        vecs[13] = mk(1, 4'hF, 4'hF, 0, 2, 4'h4, 1, 4'h0, 8'h33, 1);
        vecs[14] = mk(1, 4'hF, 4'hF, 1, 2, 4'h4, 1, 4'h4, 8'h33, 1); // accepted
        vecs[15] = mk(1, 4'h1, 4'hF, 1, 3, 4'h8, 0, 4'h8, 8'h44, 1); // granted req drops valid
        vecs[16] = mk(1, 4'h1, 4'hF, 0, 3, 4'h8, 0, 4'h0, 8'h44, 1);
        vecs[17] = mk(1, 4'h8, 4'hF, 1, 3, 4'h8, 1, 4'h8, 8'h44, 1); // sole requester re-wins
        vecs[18] = mk(1, 4'h0, 4'hF, 1, 3, 4'h8, 0, 4'h8, 8'h44, 1);
        vecs[19] = mk(1, 4'h4, 4'hF, 1, 3, 4'h8, 0, 4'h8, 8'h44, 1); // no re-arb without release
        vecs[20] = mk(0, 4'hF, 4'hF, 1, 3, 4'h8, 0, 4'h0, 8'h00, 0); // reset mid-grant
        vecs[21] = mk(1, 4'hF, 4'hF, 1, 0, 4'h0, 0, 4'h0, 8'h00, 0); // IDLE, ptr back to 0
        vecs[22] = mk(1, 4'hF, 4'hF, 1, 0, 4'h1, 1, 4'h1, 8'h11, 1);

        do_reset();
        for (int i = 0; i < 23; i++) begin
            step($sformatf("vec%0d", i), vecs[i]);
        end

`ifdef ARB_PKT_LOCK_EN
        // Packet lock: req0 sends 3 beats, last on the third; req2 waits
        do_reset();
        step("lock0", mk(1, 4'h5, 4'h0, 1, 0, 4'h0, 0, 4'h0, 8'h00, 0));
        step("lock1", mk(1, 4'h5, 4'h0, 1, 0, 4'h1, 1, 4'h1, 8'h11, 0));
        step("lock2", mk(1, 4'h5, 4'h0, 1, 0, 4'h1, 1, 4'h1, 8'h11, 0));
        step("lock3", mk(1, 4'h5, 4'h1, 1, 0, 4'h1, 1, 4'h1, 8'h11, 1));
        step("lock4", mk(1, 4'h5, 4'h0, 1, 2, 4'h4, 1, 4'h4, 8'h33, 0));

        // Forced release after MAX_BEATS=4 transfers without last
        do_reset();
        step("force0", mk(1, 4'hA, 4'h0, 1, 0, 4'h0, 0, 4'h0, 8'h00, 0));
        for (int b = 1; b <= 4; b++) begin
            step($sformatf("force%0d", b), mk(1, 4'hA, 4'h0, 1, 1, 4'h2, 1, 4'h2, 8'h22, 0));
        end
        step("force5", mk(1, 4'hA, 4'h0, 1, 3, 4'h8, 1, 4'h8, 8'h44, 0));
`else
        // One-cycle arbitration latency, stall, then per-beat re-arbitration
        do_reset();
        step("lat0", mk(1, 4'h4, 4'h0, 0, 0, 4'h0, 0, 4'h0, 8'h00, 0));
        step("lat1", mk(1, 4'h4, 4'h0, 0, 2, 4'h4, 1, 4'h0, 8'h33, 0));
        step("lat2", mk(1, 4'h4, 4'h0, 0, 2, 4'h4, 1, 4'h0, 8'h33, 0));
        step("lat3", mk(1, 4'h6, 4'h0, 1, 2, 4'h4, 1, 4'h4, 8'h33, 0));
        step("lat4", mk(1, 4'h6, 4'h0, 1, 1, 4'h2, 1, 4'h2, 8'h22, 0));
`endif

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule

// File: doc/rr_mux_arbiter.md
# rr_mux_arbiter

Round-robin arbiter and sequencer for the team's 4:1 selector datapath. Four requesters present WIDTH-bit beats with valid/ready handshakes. The block chooses one fairly, drives the 2-bit select `ss` to steer that requester's data onto a single output channel, and re-arbitrates when a transfer completes. It sits between the four source channels and one downstream sink.

## Interface
Parameters:
- `WIDTH`, default 8: data width per requester.
- `MAX_BEATS`, default 16: forced-release beat limit. Only used with `ARB_PKT_LOCK_EN`. Must be at least 1.

Ports:
- `clk`  input  1  sole clock; all state changes on rising edge.
- `rst_n`  input  1  synchronous, active-low reset.
- `req_valid`  input  4  per-requester beat valid.
- `req_data`  input  4*WIDTH  requester i occupies bits [i*WIDTH +: WIDTH].
- `req_last`  input  4  per-requester end-of-packet flag.
- `req_ready`  output  4  per-requester accept.
- `out_valid`  output  1  output beat valid.
- `out_data`  output  WIDTH  selected requester's data.
- `out_last`  output  1  selected requester's last flag.
- `out_ready`  input  1  downstream accept.
- `ss`  output  2  current select index (0..3).
- `grant`  output  4  one-hot current grant; all zero when idle.

## Operation
- Two states:
  - IDLE: no grant.
  - BUSY: one requester is granted.
- Round-robin pointer `ptr` (2 bits) holds the highest-priority index for the next arbitration.
- Pick rule: the first i in the order ptr, ptr+1, ptr+2, ptr+3 (mod 4) with `req_valid[i]`=1.
- IDLE:
  - If any `req_valid` is set, register ss = pick and grant = 1<<pick, then go to BUSY.
  - Otherwise stay in IDLE.
- BUSY datapath, all combinational through the select:
  - out_valid = req_valid[ss]
  - out_data = req_data[ss]
  - out_last = req_last[ss]
  - req_ready[i] = out_ready & grant[i]
- Transfer occurs when out_valid & out_ready.
- Release event (definition depends on configuration):
  - Release sets ptr = ss+1 mod 4.
  - In the same cycle, the block re-arbitrates using the new ptr over the current `req_valid`.
  - If a pick exists, stay in BUSY with the new ss/grant; this allows back-to-back transfers.
  - If no pick exists, go to IDLE.
- In IDLE, out_valid=0, out_last=0, out_data=0, req_ready=0. Outputs are never driven to Z.
- If the granted requester drops valid without a release, grant is held and out_valid=0. There is no re-arbitration until release.
- The select value is always in 0..3; there is no default or undefined path.

## Timing
- Reset (rst_n=0 at clock edge) forces state=IDLE, ptr=0, ss=0, grant=0, beat count=0.
  - This yields out_valid=0, req_ready=0, out_data=0, out_last=0.
  - Reset applied mid-packet abandons the packet immediately. No beat is accepted in the reset cycle.
- Arbitration latency from IDLE: 1 cycle. Valid seen at edge N gives grant and out_valid at N+1.
- Re-arbitration on release: 0 bubble cycles. The new grant is visible the cycle after the releasing transfer.
- Data path latency: 0 cycles (combinational mux).
- Simultaneous requests: resolved purely by ptr.
  - With ptr=0 and valid=4'b1111, grant order is 0,1,2,3,0.

## Configuration
- `ARB_PKT_LOCK_EN` defined (packet lock):
  - Release occurs on a transfer with out_last=1.
  - Release also occurs on the MAX_BEATS-th transfer of the grant, even without last (forced release).
  - The beat counter has width $clog2(MAX_BEATS+1). It counts transfers, clears on every new grant, and clears on reset.
- `ARB_PKT_LOCK_EN` undefined (beat mode):
  - Every transfer is a release; the arbiter interleaves per beat.
  - `req_last` passes through to `out_last` unused.
  - No counter is built.

## Structure
- Package `rr_arb_pkg` holds:
  - `NUM_REQ`=4 and `SEL_W`=2.
  - The state enum `arb_state_t` {ARB_IDLE, ARB_BUSY}.
- Sub-module `rr_pick4`: combinational picker.
  - Inputs: ptr[1:0], valid[3:0].
  - Outputs: idx[1:0], found.
  - Instantiated twice: one instance for IDLE arbitration, one for release arbitration. Alternatively a single instance with a muxed ptr.

## Test plan
- Reset check: hold rst_n=0 with all req_valid=1 and out_ready=1 → grant=0, ss=0, out_valid=0 every cycle. After release, the first grant is requester 0.
- Fairness, beat mode: all four valid, out_ready=1, each beat last=1 → ss sequence 0,1,2,3,0,1 with one transfer per cycle after the first cycle.
- Packet lock (`ARB_PKT_LOCK_EN`): req0 sends 3 beats with last on the third, req2 valid throughout → ss=0 for exactly 3 transfers, then ss=2 with no bubble.
- Forced release: MAX_BEATS=4, req1 never asserts last, req3 valid → after the 4th req1 transfer, the grant moves to 3.
- Backpressure: out_ready=0 for 5 cycles mid-packet → grant, ss, and out_data stable, and req_ready of the granted requester is 0. The first accepted beat follows out_ready=1.
- Reset mid-packet: assert rst_n=0 during req2's second beat → next cycle IDLE with grant=0. After reset, arbitration restarts with ptr=0.
